commit_pkt_assembler: RTL and testbench
=======================================

# commit_pkt_assembler

Receiver side of the split-warp commit stream. Functional units such as the SFU execute a warp as one or more NUM_LANES-wide packets, each tagged with pid/sop/eop. This block sits between such a unit's commit output and the per-issue-slot writeback path. It reassembles those packets into one THREAD_CNT-wide commit per instruction and buffers it until the writeback stage accepts it.

## Interface
Parameters:
- THREAD_CNT, `NUM_THREADS: threads per warp.
- NUM_LANES, `MIN(`NUM_SFU_LANES, THREAD_CNT): lanes per input packet. THREAD_CNT must be divisible by NUM_LANES.
- PID_WIDTH, derived as `UP(`CLOG2(THREAD_CNT/NUM_LANES)): width of the packet index.

Ports (reset is synchronous and active-high, sampled on the rising clock edge):
- clk  in  1  core clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  input packet valid.
- in_ready  out  1  input packet accepted this cycle.
- in_uuid  in  `UUID_WIDTH  instruction uuid.
- in_wid  in  `NW_WIDTH  warp id.
- in_tmask  in  NUM_LANES  lane mask of this packet.
- in_data  in  NUM_LANES*`XLEN  result data of this packet.
- in_rd  in  `NR_BITS  destination register.
- in_wb  in  1  writeback enable.
- in_PC  in  `XLEN  instruction PC.
- in_pid  in  PID_WIDTH  packet index.
- in_sop  in  1  first packet of the instruction.
- in_eop  in  1  last packet of the instruction.
- out_valid  out  1  assembled commit valid.
- out_ready  in  1  writeback accepts.
- out_uuid, out_wid, out_rd, out_wb, out_PC  out  same widths as inputs  header of the instruction.
- out_tmask  out  THREAD_CNT  full warp mask.
- out_data  out  THREAD_CNT*`XLEN  full warp data.
- proto_err  out  1  sticky protocol error flag.

## Operation
- Two storage stages: an accumulation buffer (acc) and an output register (obuf). Each stage is THREAD_CNT wide plus the header fields.
- State machine acc_state:
  - IDLE: acc is empty.
  - ACCUM: at least one packet of the current instruction has been accepted, and eop has not.
- Beat with sop=1 in IDLE:
  - acc tmask and acc data are cleared to 0.
  - The header is latched from the beat.
  - The slice at index pid (lanes pid*NUM_LANES .. +NUM_LANES-1) is written with in_tmask and in_data.
  - The state moves to ACCUM, or the beat is completed directly if eop=1.
- Beat in ACCUM: writes only its pid slice. The header is not re-latched.
- Beat with eop=1: acc merged with this beat is copied into obuf; out_valid is set; acc_state returns to IDLE.
- in_ready:
  - For non-eop beats, in_ready=1.
  - For eop beats, in_ready = ~out_valid | out_ready. An eop beat cannot overwrite obuf until obuf is drained, and the two may happen in the same cycle.
- Lanes whose slice was never written appear in the output with tmask=0 and data=0.
- Protocol errors:
  - Error cases: sop=0 in IDLE; sop=1 in ACCUM; in_wid differing from the latched wid in ACCUM.
  - Any of these sets proto_err, which stays set until reset.
  - A sop=1 beat that arrives in ACCUM restarts assembly from that beat.
  - A sop=0 beat that arrives in IDLE is dropped, but it still handshakes.
- When THREAD_CNT==NUM_LANES, every beat has sop=eop=1 and pid=0, and the block acts as a 1-deep registered pipe.

## Timing
- Latency: an eop beat accepted in cycle N gives out_valid=1 in cycle N+1.
- Throughput: one instruction per cycle in the single-packet case, with no bubble when out_ready stays high.
- Output stability: while out_valid=1 and out_ready=0, all out_* fields hold.
- Reset values: out_valid=0, proto_err=0, acc_state=IDLE, out_tmask=0. out_data and the header fields are don't-care.
- Reset mid-assembly discards acc and obuf. The first beat after reset must have sop=1.
- Simultaneous out_ready and eop accept: obuf is loaded with the new instruction and out_valid stays 1.

## Configuration
- COMMIT_ASM_PERF_EN defined:
  - Adds output perf_stalls [`PERF_CTR_BITS]: counts cycles with in_valid & ~in_ready.
  - Adds output perf_instrs [`PERF_CTR_BITS]: counts out_valid & out_ready.
  - Both counters reset to 0 and wrap modulo 2^`PERF_CTR_BITS.
- COMMIT_ASM_PERF_EN undefined: these ports and registers do not exist.

## Structure
- Shared package VX_gpu_pkg:
  - commit_hdr_t typedef: uuid, wid, rd, wb, PC.
  - Localparam helper for the PID_WIDTH derivation.
- The slice-merge is one natural sub-module, commit_slice_merge. It is combinational: it writes the NUM_LANES slice into the THREAD_CNT vector at index pid.
- The state machine, obuf and counters live in the top module.

## Test plan
- THREAD_CNT=4, NUM_LANES=4:
  - Stimulus: a single beat, sop=eop=1, tmask=4'b1011, data={4,3,2,1}.
  - Required: out_valid one cycle later, out_tmask=4'b1011, out_data={4,3,2,1}.
- THREAD_CNT=8, NUM_LANES=2:
  - Stimulus: four beats, pid 0..3, data 0x10+lane.
  - Required: one output whose data is 0x10..0x17 in order, with tmask=8'hFF.
- THREAD_CNT=8, NUM_LANES=2:
  - Stimulus: beats pid 0 and pid 2 only; the pid 2 beat has eop=1.
  - Required: out_tmask=8'b00110011 and lanes 2,3,6,7 data=0.
- Backpressure:
  - Stimulus: out_ready=0 for 5 cycles while a second instruction streams in.
  - Required: its non-eop beats are accepted; its eop beat stalls with in_ready=0 until out_ready rises; both outputs arrive in order and unchanged.
- Protocol error:
  - Stimulus: sop in ACCUM.
  - Required: proto_err=1 and stays set; the new instruction completes correctly.
- Reset mid-operation:
  - Stimulus: assert reset after 2 of 4 beats.
  - Required: out_valid=0, and the next full 4-beat instruction assembles cleanly.
  - With COMMIT_ASM_PERF_EN defined, perf_instrs=1 after this.

Source files
------------

// File: rtl/VX_gpu_pkg.sv
// rtl/VX_gpu_pkg.sv - shared widths, commit header type and pid width helper for the commit path
package VX_gpu_pkg;

   localparam int UUID_WIDTH    = 44;
   localparam int NW_WIDTH      = 4;
   localparam int NR_BITS       = 5;
   localparam int XLEN          = 32;
   localparam int PERF_CTR_BITS = 44;

   typedef struct packed {
      logic [UUID_WIDTH-1:0] uuid;
      logic [NW_WIDTH-1:0]   wid;
      logic [NR_BITS-1:0]    rd;
      logic                  wb;
      logic [XLEN-1:0]       PC;
   } commit_hdr_t;

   typedef enum logic {
      ACC_IDLE  = 1'b0,
      ACC_ACCUM = 1'b1
   } acc_state_t;

   // Never below one bit, so a single-packet warp still carries a pid field.
   function automatic int pid_width_f(input int thread_cnt, input int num_lanes);
      int num_pkts;
      num_pkts = thread_cnt / num_lanes;
      return (num_pkts > 1) ? $clog2(num_pkts) : 1;
   endfunction

endpackage

// File: rtl/commit_slice_merge.sv
// rtl/commit_slice_merge.sv - writes one NUM_LANES packet slice into a THREAD_CNT wide commit
module commit_slice_merge #(
   parameter int THREAD_CNT = 8,
   parameter int NUM_LANES  = 2,
   parameter int XLEN       = 32,
   parameter int PID_WIDTH  = 2
) (
   input  logic [THREAD_CNT-1:0]      base_tmask,
   input  logic [THREAD_CNT*XLEN-1:0] base_data,
   input  logic [PID_WIDTH-1:0]       pid,
   input  logic [NUM_LANES-1:0]       slice_tmask,
   input  logic [NUM_LANES*XLEN-1:0]  slice_data,
   output logic [THREAD_CNT-1:0]      merged_tmask,
   output logic [THREAD_CNT*XLEN-1:0] merged_data
);

   localparam int NUM_PKTS = THREAD_CNT / NUM_LANES;

   always_comb begin
      merged_tmask = base_tmask;
      merged_data  = base_data;
      for (int p = 0; p < NUM_PKTS; p++) begin
         if (pid == PID_WIDTH'(p)) begin
            merged_tmask[p*NUM_LANES +: NUM_LANES]           = slice_tmask;
            merged_data[p*NUM_LANES*XLEN +: NUM_LANES*XLEN]  = slice_data;
         end
      end
   end

endmodule

// File: rtl/commit_pkt_assembler.sv
// rtl/commit_pkt_assembler.sv - reassembles pid/sop/eop commit packets into one warp commit; COMMIT_ASM_PERF_EN adds stall/instr counters
module commit_pkt_assembler
   import VX_gpu_pkg::*;
#(
   parameter int THREAD_CNT = 8,
   parameter int NUM_LANES  = 2,
   parameter int PID_WIDTH  = pid_width_f(THREAD_CNT, NUM_LANES)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [UUID_WIDTH-1:0]     in_uuid,
   input  logic [NW_WIDTH-1:0]       in_wid,
   input  logic [NUM_LANES-1:0]      in_tmask,
   input  logic [NUM_LANES*XLEN-1:0] in_data,
   input  logic [NR_BITS-1:0]        in_rd,
   input  logic                      in_wb,
   input  logic [XLEN-1:0]           in_PC,
   input  logic [PID_WIDTH-1:0]      in_pid,
   input  logic                      in_sop,
   input  logic                      in_eop,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [UUID_WIDTH-1:0]     out_uuid,
   output logic [NW_WIDTH-1:0]       out_wid,
   output logic [THREAD_CNT-1:0]     out_tmask,
   output logic [THREAD_CNT*XLEN-1:0] out_data,
   output logic [NR_BITS-1:0]        out_rd,
   output logic                      out_wb,
   output logic [XLEN-1:0]           out_PC,
   output logic                      proto_err
`ifdef COMMIT_ASM_PERF_EN
   ,
   output logic [PERF_CTR_BITS-1:0]  perf_stalls,
   output logic [PERF_CTR_BITS-1:0]  perf_instrs
`endif
);

   acc_state_t                 acc_state, next_state;
   commit_hdr_t                in_hdr, beat_hdr, acc_hdr, obuf_hdr;
   logic [THREAD_CNT-1:0]      acc_tmask, obuf_tmask, base_tmask, merged_tmask;
   logic [THREAD_CNT*XLEN-1:0] acc_data, obuf_data, base_data, merged_data;
   logic                       beat_fire, acc_load, obuf_load, err_set, out_fire;

   assign in_hdr = '{uuid: in_uuid, wid: in_wid, rd: in_rd, wb: in_wb, PC: in_PC};

   // A sop beat starts from an empty warp, whether it opens or restarts an instruction.
   assign base_tmask = in_sop ? '0 : acc_tmask;
   assign base_data  = in_sop ? '0 : acc_data;
   assign beat_hdr   = in_sop ? in_hdr : acc_hdr;
   assign out_fire   = out_valid & out_ready;

   commit_slice_merge #(
      .THREAD_CNT (THREAD_CNT),
      .NUM_LANES  (NUM_LANES),
      .XLEN       (XLEN),
      .PID_WIDTH  (PID_WIDTH)
   ) u_slice_merge (
      .base_tmask   (base_tmask),
      .base_data    (base_data),
      .pid          (in_pid),
      .slice_tmask  (in_tmask),
      .slice_data   (in_data),
      .merged_tmask (merged_tmask),
      .merged_data  (merged_data)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_state <= ACC_IDLE;
      end else begin
         acc_state <= next_state;
      end
   end

   always_comb begin
      next_state = acc_state;
      in_ready   = in_eop ? (~out_valid | out_ready) : 1'b1;
      beat_fire  = in_valid & in_ready;
      acc_load   = 1'b0;
      obuf_load  = 1'b0;
      err_set    = 1'b0;
      if (beat_fire) begin
         case (acc_state)
            ACC_IDLE: begin
               if (!in_sop) begin
                  err_set = 1'b1;
               end else if (in_eop) begin
                  obuf_load = 1'b1;
               end else begin
                  acc_load   = 1'b1;
                  next_state = ACC_ACCUM;
               end
            end
            ACC_ACCUM: begin
               if (in_sop || (in_wid != acc_hdr.wid)) begin
                  err_set = 1'b1;
               end
               if (in_eop) begin
                  obuf_load  = 1'b1;
                  next_state = ACC_IDLE;
               end else begin
                  acc_load = 1'b1;
               end
            end
            default: next_state = ACC_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid  <= 1'b0;
         proto_err  <= 1'b0;
         acc_tmask  <= '0;
         obuf_tmask <= '0;
      end else begin
         if (acc_load) begin
            acc_tmask <= merged_tmask;
         end
         if (obuf_load) begin
            obuf_tmask <= merged_tmask;
            out_valid  <= 1'b1;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
         if (err_set) begin
            proto_err <= 1'b1;
         end
      end
   end

   // Data and header are qualified by tmask/out_valid, so they need no reset.
   always_ff @(posedge clk) begin
      if (acc_load) begin
         acc_data <= merged_data;
         acc_hdr  <= beat_hdr;
      end
      if (obuf_load) begin
         obuf_data <= merged_data;
         obuf_hdr  <= beat_hdr;
      end
   end

   assign out_uuid  = obuf_hdr.uuid;
   assign out_wid   = obuf_hdr.wid;
   assign out_rd    = obuf_hdr.rd;
   assign out_wb    = obuf_hdr.wb;
   assign out_PC    = obuf_hdr.PC;
   assign out_tmask = obuf_tmask;
   assign out_data  = obuf_data;

`ifdef COMMIT_ASM_PERF_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stalls <= '0;
         perf_instrs <= '0;
      end else begin
         if (in_valid && !in_ready) begin
            perf_stalls <= perf_stalls + PERF_CTR_BITS'(1);
         end
         if (out_fire) begin
            perf_instrs <= perf_instrs + PERF_CTR_BITS'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_commit_pkt_assembler.sv
// tb/tb_commit_pkt_assembler.sv - self-checking bench for commit_pkt_assembler in 8x2 and 4x4 builds
`timescale 1ns/1ps
module tb_commit_pkt_assembler;
   import VX_gpu_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // 8 threads / 2 lanes instance
   logic         a_in_valid, a_in_ready, a_in_wb, a_in_sop, a_in_eop;
   logic [43:0]  a_in_uuid, a_out_uuid;
   logic [3:0]   a_in_wid, a_out_wid;
   logic [1:0]   a_in_tmask, a_in_pid;
   logic [63:0]  a_in_data;
   logic [4:0]   a_in_rd, a_out_rd;
   logic [31:0]  a_in_PC, a_out_PC;
   logic         a_out_valid, a_out_ready, a_out_wb, a_proto_err;
   logic [7:0]   a_out_tmask;
   logic [255:0] a_out_data;
   // 4 threads / 4 lanes instance
   logic         b_in_valid, b_in_ready, b_in_wb, b_in_sop, b_in_eop;
   logic [43:0]  b_in_uuid, b_out_uuid;
   logic [3:0]   b_in_wid, b_out_wid;
   logic [3:0]   b_in_tmask, b_out_tmask;
   logic [0:0]   b_in_pid;
   logic [127:0] b_in_data, b_out_data;
   logic [4:0]   b_in_rd, b_out_rd;
   logic [31:0]  b_in_PC, b_out_PC;
   logic         b_out_valid, b_out_ready, b_out_wb, b_proto_err;
`ifdef COMMIT_ASM_PERF_EN
   logic [PERF_CTR_BITS-1:0] a_perf_stalls, a_perf_instrs, b_perf_stalls, b_perf_instrs;
`endif

   commit_pkt_assembler #(.THREAD_CNT(8), .NUM_LANES(2)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_uuid(a_in_uuid), .in_wid(a_in_wid), .in_tmask(a_in_tmask), .in_data(a_in_data),
      .in_rd(a_in_rd), .in_wb(a_in_wb), .in_PC(a_in_PC), .in_pid(a_in_pid),
      .in_sop(a_in_sop), .in_eop(a_in_eop), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_uuid(a_out_uuid), .out_wid(a_out_wid), .out_tmask(a_out_tmask), .out_data(a_out_data),
      .out_rd(a_out_rd), .out_wb(a_out_wb), .out_PC(a_out_PC), .proto_err(a_proto_err)
`ifdef COMMIT_ASM_PERF_EN
      , .perf_stalls(a_perf_stalls), .perf_instrs(a_perf_instrs)
`endif
   );

   commit_pkt_assembler #(.THREAD_CNT(4), .NUM_LANES(4)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_uuid(b_in_uuid), .in_wid(b_in_wid), .in_tmask(b_in_tmask), .in_data(b_in_data),
      .in_rd(b_in_rd), .in_wb(b_in_wb), .in_PC(b_in_PC), .in_pid(b_in_pid),
      .in_sop(b_in_sop), .in_eop(b_in_eop), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_uuid(b_out_uuid), .out_wid(b_out_wid), .out_tmask(b_out_tmask), .out_data(b_out_data),
      .out_rd(b_out_rd), .out_wb(b_out_wb), .out_PC(b_out_PC), .proto_err(b_proto_err)
`ifdef COMMIT_ASM_PERF_EN
      , .perf_stalls(b_perf_stalls), .perf_instrs(b_perf_instrs)
`endif
   );

   typedef struct {
      logic [3:0]   tm;
      logic [127:0] d;
      logic [43:0]  uuid;
      logic [3:0]   exp_tm;
      logic [127:0] exp_d;
   } b_vec_t;

   typedef struct {
      logic [7:0]   tm;
      logic [255:0] d;
      logic [43:0]  uuid;
      logic [31:0]  pc;
   } out_rec_t;

   out_rec_t got_q[$];
   out_rec_t exp_q[$];
   bit mon_en = 1'b0;
   bit rnd_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && !reset && a_out_valid && a_out_ready)
         got_q.push_back('{a_out_tmask, a_out_data, a_out_uuid, a_out_PC});
   end

   always @(posedge clk) begin
      if (rnd_en) begin
         #1;
         a_out_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   function automatic logic [63:0] pair(input int base, input int p);
      return {32'(base + 2*p + 1), 32'(base + 2*p)};
   endfunction

   function automatic logic [255:0] lanes(input int base, input logic [7:0] m);
      logic [255:0] v = '0;
      for (int k = 0; k < 8; k++)
         if (m[k]) v[k*32 +: 32] = 32'(base + k);
      return v;
   endfunction

   task automatic a_drive(input bit v, input int pid, input bit sop, input bit eop,
                          input logic [1:0] tm, input logic [63:0] d,
                          input logic [3:0] wid, input logic [43:0] uuid);
      a_in_valid = v;
      a_in_pid   = 2'(pid);
      a_in_sop   = sop;
      a_in_eop   = eop;
      a_in_tmask = tm;
      a_in_data  = d;
      a_in_wid   = wid;
      a_in_uuid  = uuid;
      a_in_rd    = uuid[4:0];
      a_in_wb    = 1'b1;
      a_in_PC    = uuid[31:0] ^ 32'h8000_0000;
   endtask

   // Called just after a rising edge; returns just after the edge that took the beat.
   task automatic a_beat(input int pid, input bit sop, input bit eop, input logic [1:0] tm,
                         input logic [63:0] d, input logic [3:0] wid, input logic [43:0] uuid);
      int n;
      a_drive(1'b1, pid, sop, eop, tm, d, wid, uuid);
      n = 0;
      @(negedge clk);
      while (!a_in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!a_in_ready) begin
         total++;
         bad++;
         $display("FAIL beat_timeout: in_ready still 0 after %0d cycles, want 1", n);
      end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic reset_pulse();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic a_full(input int base, input logic [43:0] uuid);
      for (int p = 0; p < 4; p++)
         a_beat(p, p == 0, p == 3, 2'b11, pair(base, p), 4'd1, uuid);
   endtask

   initial begin
      b_vec_t bv[4];
      reset = 1'b1;
      a_drive(1'b0, 0, 1'b0, 1'b0, 2'b00, 64'h0, 4'h0, 44'h0);
      a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_sop = 1'b1; b_in_eop = 1'b1; b_in_pid = 1'b0;
      b_in_tmask = '0; b_in_data = '0; b_in_uuid = '0; b_in_wid = '0;
      b_in_rd = '0; b_in_wb = 1'b1; b_in_PC = '0; b_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;

      check("rst_a_out_valid", a_out_valid, 0);
      check("rst_a_proto_err", a_proto_err, 0);
      check("rst_a_out_tmask", a_out_tmask, 0);
      check("rst_b_out_valid", b_out_valid, 0);
      check("rst_b_out_tmask", b_out_tmask, 0);

      // single-packet build: back-to-back vectors, one output per cycle
      bv[0] = '{4'b1011, {32'd4, 32'd3, 32'd2, 32'd1}, 44'h1, 4'b1011, {32'd4, 32'd3, 32'd2, 32'd1}};
      bv[1] = '{4'b0000, {32'hdead_beef, 32'h0, 32'h1234_5678, 32'hffff_ffff}, 44'h2,
                4'b0000, {32'hdead_beef, 32'h0, 32'h1234_5678, 32'hffff_ffff}};
      bv[2] = '{4'b1111, {32'ha, 32'hb, 32'hc, 32'hd}, 44'h3, 4'b1111, {32'ha, 32'hb, 32'hc, 32'hd}};
      bv[3] = '{4'b0110, {32'h55, 32'h66, 32'h77, 32'h88}, 44'h4, 4'b0110, {32'h55, 32'h66, 32'h77, 32'h88}};
      for (int i = 0; i < 4; i++) begin
         b_in_valid = 1'b1;
         b_in_tmask = bv[i].tm;
         b_in_data  = bv[i].d;
         b_in_uuid  = bv[i].uuid;
         @(negedge clk);
         check($sformatf("b_in_ready_%0d", i), b_in_ready, 1);
         @(posedge clk); #1;
         check($sformatf("b_out_valid_%0d", i), b_out_valid, 1);
         check($sformatf("b_out_tmask_%0d", i), b_out_tmask, bv[i].exp_tm);
         check($sformatf("b_out_data_%0d", i), b_out_data, bv[i].exp_d);
         check($sformatf("b_out_uuid_%0d", i), b_out_uuid, bv[i].uuid);
      end
      b_in_valid = 1'b0;
      @(posedge clk); #1;
      check("b_drained", b_out_valid, 0);

      // full four-packet instruction
      for (int p = 0; p < 4; p++) begin
         a_beat(p, p == 0, p == 3, 2'b11, pair(32'h10, p), 4'd1, 44'h100);
         if (p == 2) check("full_no_early_valid", a_out_valid, 0);
      end
      check("full_valid", a_out_valid, 1);
      check("full_tmask", a_out_tmask, 8'hFF);
      check("full_data", a_out_data, lanes(32'h10, 8'hFF));
      check("full_uuid", a_out_uuid, 44'h100);
      @(posedge clk); #1;
      check("full_drained", a_out_valid, 0);

      // sparse: pid 0 and pid 2 only
      a_beat(0, 1'b1, 1'b0, 2'b11, pair(32'h50, 0), 4'd1, 44'h150);
      a_beat(2, 1'b0, 1'b1, 2'b11, pair(32'h50, 2), 4'd1, 44'h150);
      check("sparse_tmask", a_out_tmask, 8'b0011_0011);
      check("sparse_data", a_out_data, lanes(32'h50, 8'b0011_0011));
      @(posedge clk); #1;

      // backpressure: second instruction streams in behind a held output
      a_out_ready = 1'b0;
      a_full(32'h20, 44'h200);
      check("bp_first_valid", a_out_valid, 1);
      for (int p = 0; p < 3; p++)
         a_beat(p, p == 0, 1'b0, 2'b11, pair(32'h60, p), 4'd1, 44'h300);
      check("bp_hold_data", a_out_data, lanes(32'h20, 8'hFF));
      a_drive(1'b1, 3, 1'b0, 1'b1, 2'b11, pair(32'h60, 3), 4'd1, 44'h300);
      @(negedge clk);
      check("bp_eop_stall0", a_in_ready, 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_eop_stall1", a_in_ready, 0);
      check("bp_hold_valid", a_out_valid, 1);
      check("bp_hold_uuid", a_out_uuid, 44'h200);
      check("bp_hold_data2", a_out_data, lanes(32'h20, 8'hFF));
      @(posedge clk); #1;
      a_out_ready = 1'b1;
      @(negedge clk);
      check("bp_eop_release", a_in_ready, 1);
      check("bp_first_uuid", a_out_uuid, 44'h200);
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      check("bp_second_valid", a_out_valid, 1);
      check("bp_second_data", a_out_data, lanes(32'h60, 8'hFF));
      check("bp_second_uuid", a_out_uuid, 44'h300);
      @(posedge clk); #1;
      check("bp_drained", a_out_valid, 0);

      // sop inside ACCUM restarts assembly
      a_beat(0, 1'b1, 1'b0, 2'b11, pair(32'h30, 0), 4'd2, 44'h400);
      check("err_none_yet", a_proto_err, 0);
      a_beat(1, 1'b1, 1'b0, 2'b11, pair(32'h40, 1), 4'd2, 44'h401);
      check("err_sop_in_accum", a_proto_err, 1);
      a_beat(2, 1'b0, 1'b1, 2'b11, pair(32'h40, 2), 4'd2, 44'h401);
      check("err_restart_tmask", a_out_tmask, 8'b0011_1100);
      check("err_restart_data", a_out_data, lanes(32'h40, 8'b0011_1100));
      check("err_restart_uuid", a_out_uuid, 44'h401);
      repeat (3) @(posedge clk);
      #1;
      check("err_sticky", a_proto_err, 1);

      // wid mismatch inside ACCUM
      reset_pulse();
      check("err_cleared", a_proto_err, 0);
      a_beat(0, 1'b1, 1'b0, 2'b11, pair(32'h0, 0), 4'd3, 44'h500);
      a_beat(1, 1'b0, 1'b0, 2'b11, pair(32'h0, 1), 4'd5, 44'h500);
      check("err_wid", a_proto_err, 1);
      a_beat(2, 1'b0, 1'b1, 2'b11, pair(32'h0, 2), 4'd3, 44'h500);
      @(posedge clk); #1;

      // sop=0 in IDLE is handshaken and dropped
      reset_pulse();
      a_beat(1, 1'b0, 1'b1, 2'b11, pair(32'h0, 1), 4'd1, 44'h550);
      check("idle_nosop_err", a_proto_err, 1);
      check("idle_nosop_dropped", a_out_valid, 0);

      // reset in the middle of an instruction
      reset_pulse();
      a_beat(0, 1'b1, 1'b0, 2'b11, pair(32'h70, 0), 4'd1, 44'h580);
      a_beat(1, 1'b0, 1'b0, 2'b11, pair(32'h70, 1), 4'd1, 44'h580);
      reset_pulse();
      check("midrst_valid", a_out_valid, 0);
      check("midrst_tmask", a_out_tmask, 0);
      a_full(32'h80, 44'h600);
      check("midrst_tmask_after", a_out_tmask, 8'hFF);
      check("midrst_data_after", a_out_data, lanes(32'h80, 8'hFF));
      check("midrst_uuid_after", a_out_uuid, 44'h600);
      check("midrst_no_err", a_proto_err, 0);
      @(posedge clk); #1;
`ifdef COMMIT_ASM_PERF_EN
      check("perf_instrs", a_perf_instrs, 1);
`endif

      // randomized instructions against a whole-instruction model
      reset_pulse();
      got_q.delete();
      exp_q.delete();
      mon_en = 1'b1;
      rnd_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         int k, pid, gap;
         logic [3:0] wid;
         logic [43:0] uuid;
         logic [1:0] tm;
         logic [63:0] d;
         out_rec_t e;
         k    = $urandom_range(1, 4);
         wid  = 4'($urandom);
         uuid = 44'h1000 + 44'(i);
         e.tm = '0;
         e.d  = '0;
         e.uuid = uuid;
         e.pc   = uuid[31:0] ^ 32'h8000_0000;
         for (int j = 0; j < k; j++) begin
            pid = $urandom_range(0, 3);
            tm  = 2'($urandom);
            d   = {$urandom, $urandom};
            e.tm[pid*2 +: 2] = tm;
            e.d[pid*64 +: 64] = d;
            a_beat(pid, j == 0, j == k - 1, tm, d, wid, uuid);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
               repeat (gap) @(posedge clk);
               #1;
            end
         end
         exp_q.push_back(e);
      end
      rnd_en = 1'b0;
      @(posedge clk); #2;
      a_out_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("rand_count", got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
         check($sformatf("rand_tmask_%0d", i), got_q[i].tm, exp_q[i].tm);
         check($sformatf("rand_data_%0d", i), got_q[i].d, exp_q[i].d);
         check($sformatf("rand_uuid_%0d", i), got_q[i].uuid, exp_q[i].uuid);
         check($sformatf("rand_pc_%0d", i), got_q[i].pc, exp_q[i].pc);
      end
      check("rand_no_err", a_proto_err, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
